mem_writer: RTL and testbench

MEM_WRITER -- requirements
Module: mem_writer

---
 rtl/mem_writer.sv | 182 ++++++++++++++++++
 tb/tb_mem_writer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_writer.sv
// -----------------------------------------------------------------------------
// mem_writer
//   Stores NUM_WORDS words from a valid/ready input stream into a synchronous
//   RAM. Writes start at BASE_ADDR and the address wraps modulo 2^ADDRBITS.
//   A run starts with in_start. Reset is synchronous and active high.
//
//   Optional feature (macro MEM_WRITER_VERIFY_EN):
//     After each write the block reads the word back (2 cycles, 1-cycle read
//     latency). Any mismatch sets a sticky out_error. Without the macro the
//     VERIFY state is never entered, out_error is 0 and in_mem_data is unused.
//
// Ports
//   in_clk        single clock, rising edge
//   in_rst        synchronous active-high reset
//   in_start      start a run (honoured in IDLE/DONE only)
//   in_data       stream word
//   in_valid      in_data is valid
//   out_ready     block accepts in_data this cycle (high exactly in LOAD)
//   out_mem_addr  memory address (held outside WRITE/VERIFY)
//   out_mem_data  memory write data (held outside WRITE/VERIFY)
//   out_mem_write memory write enable (high exactly in WRITE)
//   in_mem_data   memory read data, one cycle after the address
//   out_busy      high in LOAD, WRITE and VERIFY
//   out_done      last run completed; cleared by an accepted start or reset
//   out_error     sticky verify mismatch (always 0 without the macro)
//   out_state     debug view of the FSM state encoding
// -----------------------------------------------------------------------------
module mem_writer #(
  parameter int ADDRBITS  = 3,
  parameter int DATABITS  = 8,
  parameter int BASE_ADDR = 0,
  parameter int NUM_WORDS = 4
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_start,
  input  logic [DATABITS-1:0] in_data,
  input  logic                in_valid,
  output logic                out_ready,
  output logic [ADDRBITS-1:0] out_mem_addr,
  output logic [DATABITS-1:0] out_mem_data,
  output logic                out_mem_write,
  input  logic [DATABITS-1:0] in_mem_data,
  output logic                out_busy,
  output logic                out_done,
  output logic                out_error,
  output logic [2:0]          out_state
);

  // The count must be able to hold NUM_WORDS = 2^ADDRBITS, so it needs one extra bit.
  localparam int CNTBITS = ADDRBITS + 1;
  localparam logic [ADDRBITS-1:0] BASE = ADDRBITS'(BASE_ADDR);
  localparam logic [CNTBITS-1:0]  LAST = CNTBITS'(NUM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WRITE  = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state;
  logic [ADDRBITS-1:0] address;
  logic [CNTBITS-1:0]  count;
  logic [CNTBITS-1:0]  count_inc;
  logic                last_word;

  assign count_inc = count + CNTBITS'(1);
  assign last_word = (count_inc == LAST);
  assign out_state = state;

`ifdef MEM_WRITER_VERIFY_EN
  // 0: address presented to the RAM, 1: read data is on in_mem_data.
  logic verify_phase;
`else
  assign out_error = 1'b0;
  logic unused_mem_data;
  assign unused_mem_data = ^in_mem_data;
`endif

  // Handshake: a word transfers on a rising edge where in_valid and out_ready
  // are both 1. out_ready is registered and depends only on the state, never
  // on in_valid. The source holds in_data stable until the transfer happens.
  // in_valid is ignored whenever out_ready is 0.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state         <= S_IDLE;
      address       <= BASE;
      count         <= '0;
      out_mem_addr  <= BASE;
      out_mem_data  <= '0;
      out_mem_write <= 1'b0;
      out_ready     <= 1'b0;
      out_busy      <= 1'b0;
      out_done      <= 1'b0;
`ifdef MEM_WRITER_VERIFY_EN
      out_error     <= 1'b0;
      verify_phase  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (in_start) begin
            address  <= BASE;
            count    <= '0;
            out_done <= 1'b0;
`ifdef MEM_WRITER_VERIFY_EN
            out_error <= 1'b0;
`endif
            if (NUM_WORDS == 0) begin
              // An empty run completes immediately, without a LOAD cycle.
              state    <= S_DONE;
              out_done <= 1'b1;
            end else begin
              state     <= S_LOAD;
              out_ready <= 1'b1;
              out_busy  <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (in_valid) begin
            out_mem_data  <= in_data;
            out_mem_addr  <= address;
            out_mem_write <= 1'b1;
            out_ready     <= 1'b0;
            state         <= S_WRITE;
          end
        end

        S_WRITE: begin
          out_mem_write <= 1'b0;
`ifdef MEM_WRITER_VERIFY_EN
          state        <= S_VERIFY;
          verify_phase <= 1'b0;
`else
          count   <= count_inc;
          address <= address + ADDRBITS'(1);
          if (last_word) begin
            state    <= S_DONE;
            out_busy <= 1'b0;
            out_done <= 1'b1;
          end else begin
            state     <= S_LOAD;
            out_ready <= 1'b1;
          end
`endif
        end

`ifdef MEM_WRITER_VERIFY_EN
        S_VERIFY: begin
          if (!verify_phase) begin
            verify_phase <= 1'b1;
          end else begin
            verify_phase <= 1'b0;
            if (in_mem_data != out_mem_data) begin
              out_error <= 1'b1;
            end
            count   <= count_inc;
            address <= address + ADDRBITS'(1);
            if (last_word) begin
              state    <= S_DONE;
              out_busy <= 1'b0;
              out_done <= 1'b1;
            end else begin
              state     <= S_LOAD;
              out_ready <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_writer.sv
// -----------------------------------------------------------------------------
// tb_mem_writer
//   Three instances of mem_writer share one clock:
//     u0 default (BASE 0, 4 words), u1 BASE 6 (wraps), u2 NUM_WORDS 0.
//   Each instance has a small RAM model on its memory port. A negedge
//   process holds a write-level model of every instance: the expected write
//   beats, busy/done/error timelines and held address/data. It checks every
//   instance on every cycle. Directed tests add literal checks on RAM contents
//   and run latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_writer;
  localparam int N = 3;
`ifdef MEM_WRITER_VERIFY_EN
  localparam int DONE_LAT = 3;   // cycles from the last write cycle to done
  localparam int RUN_LAT  = 17;  // start cycle to first done cycle, 4 words
`else
  localparam int DONE_LAT = 1;
  localparam int RUN_LAT  = 9;
`endif
  localparam int ERR_LAT = 3;    // write cycle to visible out_error

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [N-1:0]       rst, start, valid;
  logic [N-1:0][7:0]  din;
  logic [N-1:0]       ready, mwrite, busy, done, err;
  logic [N-1:0][2:0]  maddr;
  logic [N-1:0][7:0]  mdata, rdata;
  logic [N-1:0][2:0]  dbg_state;

  mem_writer #(.ADDRBITS(3), .DATABITS(8), .BASE_ADDR(0), .NUM_WORDS(4)) u0 (
    .in_clk(clk), .in_rst(rst[0]), .in_start(start[0]), .in_data(din[0]),
    .in_valid(valid[0]), .out_ready(ready[0]), .out_mem_addr(maddr[0]),
    .out_mem_data(mdata[0]), .out_mem_write(mwrite[0]), .in_mem_data(rdata[0]),
    .out_busy(busy[0]), .out_done(done[0]), .out_error(err[0]), .out_state(dbg_state[0]));

  mem_writer #(.ADDRBITS(3), .DATABITS(8), .BASE_ADDR(6), .NUM_WORDS(4)) u1 (
    .in_clk(clk), .in_rst(rst[1]), .in_start(start[1]), .in_data(din[1]),
    .in_valid(valid[1]), .out_ready(ready[1]), .out_mem_addr(maddr[1]),
    .out_mem_data(mdata[1]), .out_mem_write(mwrite[1]), .in_mem_data(rdata[1]),
    .out_busy(busy[1]), .out_done(done[1]), .out_error(err[1]), .out_state(dbg_state[1]));

  mem_writer #(.ADDRBITS(3), .DATABITS(8), .BASE_ADDR(0), .NUM_WORDS(0)) u2 (
    .in_clk(clk), .in_rst(rst[2]), .in_start(start[2]), .in_data(din[2]),
    .in_valid(valid[2]), .out_ready(ready[2]), .out_mem_addr(maddr[2]),
    .out_mem_data(mdata[2]), .out_mem_write(mwrite[2]), .in_mem_data(rdata[2]),
    .out_busy(busy[2]), .out_done(done[2]), .out_error(err[2]), .out_state(dbg_state[2]));

  // ---------------- bench RAMs (synchronous read, 1-cycle latency) ----------------
  logic [7:0] ram [N][8];
  logic       force_ff = 1'b0;   // makes u0's address 2 read back as 0xff
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (mwrite[i]) ram[i][maddr[i]] <= mdata[i];
      rdata[i] <= (force_ff && i == 0 && maddr[i] == 3'd2) ? 8'hff : ram[i][maddr[i]];
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int base_of(input int i);
    return (i == 1) ? 6 : 0;
  endfunction
  function automatic int num_of(input int i);
    return (i == 2) ? 0 : 4;
  endfunction

  // Expected write beats: {instance[1:0], addr[2:0], data[7:0]}.
  logic [12:0] exp_q[$];
  logic [7:0]  words [4];

  bit         in_run [N];
  bit         exp_done [N];
  bit         exp_err [N];
  bit         hs_prev [N];
  int         writes_left [N];
  int         done_in [N];
  int         err_in [N];
  logic [2:0] last_addr [N];
  logic [7:0] last_data [N];
  logic [12:0] beat;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      // scheduled events that become visible this cycle
      if (done_in[i] > 0) begin
        done_in[i]--;
        if (done_in[i] == 0) begin
          exp_done[i] = 1'b1;
          in_run[i]   = 1'b0;
        end
      end
      if (err_in[i] > 0) begin
        err_in[i]--;
        if (err_in[i] == 0) exp_err[i] = 1'b1;
      end

      if (chk_en) begin
        check($sformatf("busy[%0d]", i), busy[i], in_run[i]);
        check($sformatf("done[%0d]", i), done[i], exp_done[i]);
        check($sformatf("error[%0d]", i), err[i], exp_err[i]);
        check($sformatf("write_after_accept[%0d]", i), mwrite[i], hs_prev[i]);
        check($sformatf("ready_and_write[%0d]", i), ready[i] & mwrite[i], 1'b0);
`ifndef MEM_WRITER_VERIFY_EN
        check($sformatf("busy_is_load_or_write[%0d]", i), busy[i], ready[i] | mwrite[i]);
`else
        check($sformatf("ready_implies_busy[%0d]", i), ready[i] & ~busy[i], 1'b0);
`endif
        if (mwrite[i]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write[%0d]: got addr %0h data %0h, expected no write", i, maddr[i], mdata[i]);
          end else begin
            beat = exp_q.pop_front();
            check($sformatf("write_beat[%0d]", i), {2'(i), maddr[i], mdata[i]}, beat);
            last_addr[i] = beat[10:8];
            last_data[i] = beat[7:0];
            writes_left[i]--;
            if (writes_left[i] == 0) done_in[i] = DONE_LAT;
`ifdef MEM_WRITER_VERIFY_EN
            if (force_ff && i == 0 && beat[10:8] == 3'd2 && beat[7:0] != 8'hff) err_in[i] = ERR_LAT;
`endif
          end
        end else begin
          check($sformatf("addr_hold[%0d]", i), maddr[i], last_addr[i]);
          check($sformatf("data_hold[%0d]", i), mdata[i], last_data[i]);
        end
      end

      // events at the edge closing this cycle
      hs_prev[i] = valid[i] & ready[i] & ~rst[i];
      if (rst[i]) begin
        in_run[i]      = 1'b0;
        exp_done[i]    = 1'b0;
        exp_err[i]     = 1'b0;
        done_in[i]     = 0;
        err_in[i]      = 0;
        writes_left[i] = 0;
        last_addr[i]   = 3'(base_of(i));
        last_data[i]   = 8'h00;
      end else if (start[i] && !in_run[i]) begin
        exp_done[i] = 1'b0;
        exp_err[i]  = 1'b0;
        err_in[i]   = 0;
        if (num_of(i) == 0) begin
          done_in[i] = 1;
        end else begin
          in_run[i]      = 1'b1;
          writes_left[i] = num_of(i);
          done_in[i]     = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_exp(input int i, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({2'(i), 3'(base_of(i) + k), words[k]});
  endtask

  task automatic do_start(input int i, output int t0);
    start[i] = 1'b1;
    t0 = cycle;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic stream(input int i, input int n, input bit rnd);
    int k = 0;
    int guard = 0;
    bit hs;
    while (k < n && guard < 200) begin
      din[i]   = words[k];
      valid[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = valid[i] & ready[i];
      @(posedge clk); #1;
      if (hs) k++;
      guard++;
    end
    valid[i] = 1'b0;
    check($sformatf("stream_accepts[%0d]", i), k, n);
  endtask

  task automatic wait_done(input int i, input int t0, input int exp_lat, input string name);
    int guard = 0;
    while (!done[i] && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_lat >= 0) check(name, done[i] ? (cycle - t0) : -1, exp_lat);
    else check(name, done[i], 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- directed tests ----------------
  int t0;
  initial begin
    rst = '1; start = '0; valid = '0; din = '0;
    repeat (2) @(posedge clk); #1;
    chk_en = 1'b1;
    rst = '0;

    // reset values
    check("rst_ready", ready[0], 1'b0);
    check("rst_busy", busy[0], 1'b0);
    check("rst_done", done[0], 1'b0);
    check("rst_write", mwrite[0], 1'b0);
    check("rst_data", mdata[0], 8'h00);
    check("rst_error", err[0], 1'b0);

    // 1: constant valid, default parameters
    words = '{8'ha1, 8'ha2, 8'ha3, 8'ha4};
    load_exp(0, 4);
    do_start(0, t0);
    stream(0, 4, 1'b0);
    wait_done(0, t0, RUN_LAT, "t1_run_latency");
    check("t1_ram0", ram[0][0], 8'ha1);
    check("t1_ram1", ram[0][1], 8'ha2);
    check("t1_ram2", ram[0][2], 8'ha3);
    check("t1_ram3", ram[0][3], 8'ha4);

    // 2: random valid, plus a start pulse that must be ignored mid-run
    words = '{8'hd1, 8'hd2, 8'hd3, 8'hd4};
    load_exp(0, 4);
    do_start(0, t0);
    fork
      stream(0, 4, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
      end
    join
    wait_done(0, t0, -1, "t2_done");
    check("t2_ram0", ram[0][0], 8'hd1);
    check("t2_ram3", ram[0][3], 8'hd4);

    // 3: BASE_ADDR 6 wraps through 6,7,0,1
    words = '{8'hc1, 8'hc2, 8'hc3, 8'hc4};
    load_exp(1, 4);
    do_start(1, t0);
    stream(1, 4, 1'b0);
    wait_done(1, t0, RUN_LAT, "t3_run_latency");
    check("t3_ram6", ram[1][6], 8'hc1);
    check("t3_ram7", ram[1][7], 8'hc2);
    check("t3_ram0", ram[1][0], 8'hc3);
    check("t3_ram1", ram[1][1], 8'hc4);
    check("t3_error", err[1], 1'b0);

    // 4: reset after two accepted words, then a fresh run
    words = '{8'hb1, 8'hb2, 8'hb3, 8'hb4};
    load_exp(0, 2);
    do_start(0, t0);
    stream(0, 2, 1'b0);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    check("t4_ready", ready[0], 1'b0);
    check("t4_busy", busy[0], 1'b0);
    check("t4_done", done[0], 1'b0);
    check("t4_write", mwrite[0], 1'b0);
    check("t4_data", mdata[0], 8'h00);
    check("t4_error", err[0], 1'b0);
    check("t4_ram0", ram[0][0], 8'hb1);
    check("t4_ram1", ram[0][1], 8'hb2);
    check("t4_ram2_untouched", ram[0][2], 8'hd3);
    words = '{8'hf1, 8'hf2, 8'hf3, 8'hf4};
    load_exp(0, 4);
    do_start(0, t0);
    stream(0, 4, 1'b0);
    wait_done(0, t0, RUN_LAT, "t4_rerun_latency");
    check("t4_rerun_ram0", ram[0][0], 8'hf1);
    check("t4_rerun_ram2", ram[0][2], 8'hf3);

    // 5: NUM_WORDS 0 completes one cycle after start
    do_start(2, t0);
    wait_done(2, t0, 1, "t5_empty_latency");
    check("t5_ready", ready[2], 1'b0);

`ifdef MEM_WRITER_VERIFY_EN
    // 6: read-back of address 2 is forced to 0xff, so out_error must stick
    force_ff = 1'b1;
    words = '{8'he1, 8'he2, 8'he3, 8'he4};
    load_exp(0, 4);
    do_start(0, t0);
    stream(0, 4, 1'b0);
    wait_done(0, t0, RUN_LAT, "t6_run_latency");
    check("t6_error_set", err[0], 1'b1);
    force_ff = 1'b0;
    load_exp(0, 4);
    do_start(0, t0);
    check("t6_error_cleared", err[0], 1'b0);
    stream(0, 4, 1'b0);
    wait_done(0, t0, RUN_LAT, "t6_clean_latency");
    check("t6_clean_error", err[0], 1'b0);
`endif

    repeat (4) @(posedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
